// File: rtl/sensor_alarm_pkg.sv
// Shared types and constants for the multi-channel sensor alarm controller.
package sensor_alarm_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DEB   = 2'd1;
    localparam logic [1:0] S_ALARM = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        DEB   = S_DEB,
        ALARM = S_ALARM
    } chan_state_e;

    localparam int                EVT_W   = 8;
    localparam logic [EVT_W-1:0]  EVT_MAX = '1;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sensor_alarm_ctrl_if.sv
// Sensor/buzzer bundle between the pin-level wrapper (master) and the alarm controller (slave).
interface sensor_alarm_ctrl_if #(parameter int N_CH = 8);
    import sensor_alarm_pkg::*;

    localparam int ID_W = id_width(N_CH);

    logic              ena;
    logic [N_CH-1:0]   sensor;
    logic [N_CH-1:0]   ack;
    logic              latch_en;
    logic              mute;
    logic [N_CH-1:0]   buzz;
    logic [N_CH-1:0]   alarm;
    logic              alarm_any;
    logic [ID_W-1:0]   alarm_id;
    logic [EVT_W-1:0]  event_cnt;

    modport master (
        output ena, sensor, ack, latch_en, mute,
        input  buzz, alarm, alarm_any, alarm_id, event_cnt
    );

    modport slave (
        input  ena, sensor, ack, latch_en, mute,
        output buzz, alarm, alarm_any, alarm_id, event_cnt
    );

endinterface

// File: rtl/sensor_chan_fsm.sv
// One alarm channel: debounce counter plus IDLE/DEB/ALARM state with optional latching.
module sensor_chan_fsm
    import sensor_alarm_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic ena_i,
    input  logic sensor_i,
    input  logic ack_i,
    input  logic latch_en_i,
    output logic alarm_o,
    output logic entry_o
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             entry_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        state_d = state_q;
        cnt_d   = cnt_q;
        entry_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sensor_i) begin
                    if (DEBOUNCE == 1) begin
                        state_d = S_ALARM;
                        entry_d = 1'b1;
                    end else begin
                        state_d = S_DEB;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            S_DEB: begin
                if (!sensor_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE)) begin
                    state_d = S_ALARM;
                    cnt_d   = '0;
                    entry_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ALARM: begin
                // A latched alarm only clears once the cause is gone and the operator acknowledges.
                if (!sensor_i && (!latch_en_i || ack_i)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else if (ena_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alarm_o = (state_q == S_ALARM);
    assign entry_o = entry_d & ena_i;

endmodule

// File: rtl/sensor_alarm_ctrl.sv
// Multi-channel alarm controller: per-channel FSMs, shared beep tone, priority id, event counter.
module sensor_alarm_ctrl
    import sensor_alarm_pkg::*;
#(
    parameter int N_CH      = 8,
    parameter int DEBOUNCE  = 3,
    parameter int BEEP_HALF = 4
) (
    input  logic              clk,
    input  logic              rst,
    sensor_alarm_ctrl_if.slave bus_if
);

    localparam int ID_W   = id_width(N_CH);
    localparam int TONE_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
    localparam int SUM_W  = EVT_W + 1;

    logic [N_CH-1:0]   alarm_w;
    logic [N_CH-1:0]   entry_w;
    logic              alarm_any_w;
    logic [ID_W-1:0]   alarm_id_w;
    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              tone_q, tone_d;
    logic [EVT_W-1:0]  event_cnt_q, event_cnt_d;
    logic [SUM_W-1:0]  evt_sum;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        sensor_chan_fsm #(.DEBOUNCE(DEBOUNCE)) u_chan (
            .clk        (clk),
            .rst        (rst),
            .ena_i      (bus_if.ena),
            .sensor_i   (bus_if.sensor[g]),
            .ack_i      (bus_if.ack[g]),
            .latch_en_i (bus_if.latch_en),
            .alarm_o    (alarm_w[g]),
            .entry_o    (entry_w[g])
        );
    end

    assign alarm_any_w = |alarm_w;

    // Tone phase restarts only when the whole controller is quiet, so joining channels share it.
    always_comb begin
        tone_cnt_d = tone_cnt_q;
        tone_d     = tone_q;
        if (!alarm_any_w) begin
            tone_cnt_d = '0;
            tone_d     = 1'b1;
        end else if (tone_cnt_q == TONE_W'(BEEP_HALF - 1)) begin
            tone_cnt_d = '0;
            tone_d     = ~tone_q;
        end else begin
            tone_cnt_d = tone_cnt_q + TONE_W'(1);
        end
    end

    always_comb begin
        // NOTE: blocking assignments here build the running sum in sequence within one evaluation.
        evt_sum = SUM_W'(event_cnt_q);
        for (int i = 0; i < N_CH; i++) begin
            evt_sum = evt_sum + SUM_W'(entry_w[i]);
        end
        event_cnt_d = (evt_sum > SUM_W'(EVT_MAX)) ? EVT_MAX : evt_sum[EVT_W-1:0];
    end

    always_comb begin
        alarm_id_w = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (alarm_w[i]) alarm_id_w = ID_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_cnt_q  <= '0;
            tone_q      <= 1'b0;
            event_cnt_q <= '0;
        end else if (bus_if.ena) begin
            tone_cnt_q  <= tone_cnt_d;
            tone_q      <= tone_d;
            event_cnt_q <= event_cnt_d;
        end
    end

    assign bus_if.alarm     = alarm_w;
    assign bus_if.alarm_any = alarm_any_w;
    assign bus_if.alarm_id  = alarm_id_w;
    assign bus_if.event_cnt = event_cnt_q;
    assign bus_if.buzz      = alarm_w & {N_CH{tone_q & ~bus_if.mute}};

endmodule

// File: doc/sensor_alarm_ctrl.md
Name: sensor_alarm_ctrl

Overview:
Parametrised multi-channel sensor-to-buzzer alarm controller, successor to the fixed 8-sensor/8-buzzer state machine at the tt_um_aditya_patra top level.
Adds per-channel debounce, optional alarm latching with per-channel acknowledge, a shared beep-pattern generator, global mute, priority encoding of the active channel and a saturating alarm-event counter.
Sits between the ui_in sensor pins and the uo_out buzzer pins; status fields go to the uio bus.

Parameters:
N_CH, 8, number of sensor/buzzer channels (1..16)
DEBOUNCE, 3, consecutive high samples required to raise an alarm (>=1)
BEEP_HALF, 4, cycles per tone half-period (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
ena  in  1  global enable; 0 freezes all state, counters and outputs
sensor  in  N_CH  raw sensor inputs, sampled on each enabled edge
ack  in  N_CH  per-channel acknowledge, level-sampled
latch_en  in  1  1 = alarms latch until acknowledged; 0 = alarms follow the sensor
mute  in  1  forces buzz to 0; alarm state is unaffected
buzz  out  N_CH  buzzer drive, pulsed with the tone pattern
alarm  out  N_CH  channel in ALARM state
alarm_any  out  1  OR of alarm
alarm_id  out  max(1,$clog2(N_CH))  lowest-index channel in alarm; 0 when none
event_cnt  out  8  count of alarm entries, saturates at 255

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, named rst.
- Reset:
  - All channels go to IDLE.
  - Debounce counters, tone counter, tone and event_cnt clear to 0.
  - All outputs are 0.
  - Reset asserted mid-alarm clears the channel immediately, without waiting for a clock edge.
- Per-channel FSM, advancing only on edges with ena=1:
  - IDLE: if sensor=1, go to DEB with cnt=1. If DEBOUNCE=1, go directly to ALARM.
  - DEB: if sensor=0, go to IDLE and set cnt=0. Otherwise cnt+1; when cnt+1 == DEBOUNCE, go to ALARM.
  - Result: alarm rises on the edge that samples the DEBOUNCE-th consecutive high.
  - ALARM, latch_en=0: sensor=0 returns the channel to IDLE on that edge.
  - ALARM, latch_en=1: the channel leaves to IDLE only when ack=1 and sensor=0 on the same edge. ack while sensor=1 is ignored.
  - ack in IDLE or DEB has no effect.
  - latch_en is sampled each edge. Clearing it while a channel is latched with sensor=0 returns that channel to IDLE on the next edge.
- alarm[i] is a direct decode of the registered state (no extra latency).
- Tone generator, shared across channels:
  - While alarm_any=0, the tone counter is 0 and tone=1.
  - While alarm_any=1, the counter runs 0..BEEP_HALF-1 and tone toggles at each wrap.
  - The first BEEP_HALF cycles of any alarm episode therefore have tone=1.
  - A second channel joining an ongoing episode does not restart the phase.
- buzz[i] = alarm[i] & tone & ~mute, combinational from registers.
- alarm_id: fixed priority, lowest index wins.
- event_cnt:
  - On each enabled edge, adds the number of channels entering ALARM that edge.
  - Simultaneous entries are all counted.
  - The sum saturates at 255 and never wraps.
- ena=0: nothing updates, and outputs hold their last values.

Decomposition:
- Shared package sensor_alarm_pkg holds:
  - the channel state enum (IDLE, DEB, ALARM);
  - the event-counter width constant EVT_W=8 and saturation max;
  - the helper function for alarm_id width.
- One sub-module, sensor_chan_fsm: a single channel's FSM plus debounce counter.
  - Inputs: sensor, ack, latch_en, ena.
  - Outputs: alarm and an entry pulse.
  - Instantiated N_CH times by a generate loop.
- The top level holds the tone generator, priority encoder and event counter.

Test Plan:
1. Reset then debounce (N_CH=8, DEBOUNCE=3, BEEP_HALF=4): sensor=0x01 held -> alarm=0x01 at the 3rd sampled edge; event_cnt=1; alarm_id=0; buzz[0] high 4 cycles, low 4, repeating.
2. Glitch rejection: sensor[2] high for 2 edges then low -> alarm stays 0x00 and event_cnt is unchanged.
3. Latching: latch_en=1, sensor[1] alarm then sensor=0 -> alarm stays 0x02. ack[1] with sensor[1]=1 is ignored. ack[1] with sensor[1]=0 -> alarm=0x00 on the next edge.
4. Simultaneous/priority: sensor=0x06 from IDLE -> alarm=0x06 on the same edge; event_cnt +2; alarm_id=1; mute=1 -> buzz=0x00 while alarm stays 0x06.
5. All channels and saturation: preload event_cnt to 250 via repeated alarm entries, then sensor=0xFF -> event_cnt=255 and stays there on later entries; alarm_any=1.
6. Async reset mid-alarm: assert rst between clock edges during an active alarm -> all outputs read 0 before the next edge; after release, sensor held high needs a fresh 3-edge debounce.
